// File: rtl/alu_unit.sv
// RV32I execute-stage ALU: a combinational integer result, an address result
// and an illegal-encoding fault, plus a fault flag that holds until reset.
module alu_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      alu_op,
  input  logic [1:0]      addr_alu_op,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] addr_alu_out,
  output logic            fault,
  output logic            fault_sticky
);

  localparam logic [2:0] OP_LUI   = 3'd0;
  localparam logic [2:0] OP_LINK  = 3'd1;
  localparam logic [2:0] OP_AUIPC = 3'd2;
  localparam logic [2:0] OP_RSV3  = 3'd3;
  localparam logic [2:0] OP_STORE = 3'd4;
  localparam logic [2:0] OP_IMM   = 3'd5;
  localparam logic [2:0] OP_REG   = 3'd6;
  localparam logic [2:0] OP_RSV7  = 3'd7;

  logic [XLEN-1:0] op_b_s;
  logic [4:0]      shamt_s;
  logic            alt_s;
  logic [XLEN-1:0] arith_s;
  logic            enc_fault_s;
  logic            fault_sticky_d;
  logic            fault_sticky_q;

  // Operand B and shift amount come from imm for OP-IMM and from rs2 for OP.
  always_comb begin
    op_b_s  = imm;
    shamt_s = imm[4:0];
    if (alu_op == OP_REG) begin
      op_b_s  = rs2;
      shamt_s = rs2[4:0];
    end else begin
      op_b_s  = imm;
      shamt_s = imm[4:0];
    end
  end

  // imm[10] is instruction bit 30: SUB for OP add, SRA for either shift-right.
  assign alt_s = imm[10];

  always_comb begin
    arith_s = {XLEN{1'b0}};
    case (funct3)
      3'd0: begin
        if ((alu_op == OP_REG) && alt_s) begin
          arith_s = rs1 - op_b_s;
        end else begin
          arith_s = rs1 + op_b_s;
        end
      end
      3'd1: arith_s = rs1 << shamt_s;
      3'd2: arith_s = ($signed(rs1) < $signed(op_b_s)) ? 32'd1 : 32'd0;
      3'd3: arith_s = (rs1 < op_b_s) ? 32'd1 : 32'd0;
      3'd4: arith_s = rs1 ^ op_b_s;
      3'd5: begin
        if (alt_s) begin
          arith_s = $signed(rs1) >>> shamt_s;
        end else begin
          arith_s = rs1 >> shamt_s;
        end
      end
      3'd6: arith_s = rs1 | op_b_s;
      3'd7: arith_s = rs1 & op_b_s;
      default: arith_s = {XLEN{1'b0}};
    endcase
  end

  // Encoding checks that still let the decoded result through.
  always_comb begin
    enc_fault_s = 1'b0;
    if (alu_op == OP_IMM) begin
      if ((funct3 == 3'd1) && (imm[11:5] != 7'h00)) begin
        enc_fault_s = 1'b1;
      end else if ((funct3 == 3'd5) && (imm[11:5] != 7'h00) && (imm[11:5] != 7'h20)) begin
        enc_fault_s = 1'b1;
      end else begin
        enc_fault_s = 1'b0;
      end
    end else if (alu_op == OP_REG) begin
      if (alt_s && (funct3 != 3'd0) && (funct3 != 3'd5)) begin
        enc_fault_s = 1'b1;
      end else begin
        enc_fault_s = 1'b0;
      end
    end else begin
      enc_fault_s = 1'b0;
    end
  end

  always_comb begin
    alu_out = {XLEN{1'b0}};
    fault   = 1'b0;
    case (alu_op)
      OP_LUI:   alu_out = imm;
      OP_LINK:  alu_out = pc + 32'd4;
      OP_AUIPC: alu_out = pc + imm;
      OP_RSV3: begin
        alu_out = {XLEN{1'b0}};
        fault   = 1'b1;
      end
      OP_STORE: alu_out = rs2;
      OP_IMM, OP_REG: begin
        alu_out = arith_s;
        fault   = enc_fault_s;
      end
      OP_RSV7: begin
        alu_out = {XLEN{1'b0}};
        fault   = 1'b1;
      end
      default: begin
        alu_out = {XLEN{1'b0}};
        fault   = 1'b1;
      end
    endcase
  end

  always_comb begin
    addr_alu_out = pc;
    case (addr_alu_op)
      2'd0:    addr_alu_out = pc;
      2'd1:    addr_alu_out = pc + imm;
      2'd2:    addr_alu_out = rs1 + imm;
      2'd3:    addr_alu_out = pc + 32'd2;
      default: addr_alu_out = pc;
    endcase
  end

  assign fault_sticky_d = fault_sticky_q | fault;

  // Sticky fault flag; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_sticky_q <= 1'b0;
    end else begin
      fault_sticky_q <= fault_sticky_d;
    end
  end

  assign fault_sticky = fault_sticky_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vector table, fault/reset
// sequence, and random stimulus against an arithmetic reference model.
module tb_alu_unit;

  logic        clk;
  logic        rst_n;
  logic [2:0]  alu_op;
  logic [1:0]  addr_alu_op;
  logic [31:0] imm, rs1, rs2, pc;
  logic [2:0]  funct3;
  logic [31:0] alu_out, addr_alu_out;
  logic        fault, fault_sticky;

  int errors = 0;
  int checks = 0;

  alu_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .addr_alu_op(addr_alu_op),
    .imm(imm), .rs1(rs1), .rs2(rs2), .pc(pc), .funct3(funct3),
    .alu_out(alu_out), .addr_alu_out(addr_alu_out),
    .fault(fault), .fault_sticky(fault_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  aop;
    logic [2:0]  f3;
    logic [31:0] pc, rs1, rs2, imm;
    logic [31:0] exp_out;
    logic [31:0] exp_addr;
    logic        exp_fault;
  } vec_t;

  vec_t vec_q[$];

  task automatic add_vec(input logic [2:0] op, input logic [1:0] aop, input logic [2:0] f3,
                         input logic [31:0] vpc, input logic [31:0] vrs1, input logic [31:0] vrs2,
                         input logic [31:0] vimm, input logic [31:0] eo, input logic [31:0] ea,
                         input logic ef);
    vec_t v;
    v.op = op; v.aop = aop; v.f3 = f3; v.pc = vpc; v.rs1 = vrs1; v.rs2 = vrs2;
    v.imm = vimm; v.exp_out = eo; v.exp_addr = ea; v.exp_fault = ef;
    vec_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] aop, input logic [2:0] f3,
                       input logic [31:0] vpc, input logic [31:0] vrs1, input logic [31:0] vrs2,
                       input logic [31:0] vimm);
    alu_op = op; addr_alu_op = aop; funct3 = f3; pc = vpc; rs1 = vrs1; rs2 = vrs2; imm = vimm;
  endtask

  // Reference: integer arithmetic on 64-bit values, then reduced modulo 2^32.
  function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [2:0] f3,
                                          input logic [31:0] vpc, input logic [31:0] vrs1,
                                          input logic [31:0] vrs2, input logic [31:0] vimm);
    logic [31:0] b, r;
    logic flt;
    longint unsigned ua, ub, p;
    longint sa, sb, q;
    int sh;
    b = (op == 3'd6) ? vrs2 : vimm;
    sh = int'(b[4:0]);
    ua = {32'd0, vrs1};
    ub = {32'd0, b};
    sa = longint'($signed(vrs1));
    sb = longint'($signed(b));
    p = 64'd1 << sh;
    r = 32'd0;
    flt = 1'b0;
    case (op)
      3'd0: r = vimm;
      3'd1: r = 32'(({32'd0, vpc} + 64'd4) % 64'h1_0000_0000);
      3'd2: r = 32'(({32'd0, vpc} + {32'd0, vimm}) % 64'h1_0000_0000);
      3'd4: r = vrs2;
      3'd5, 3'd6: begin
        case (f3)
          3'd0: begin
            if (op == 3'd6 && vimm[10]) r = 32'((ua + (64'h1_0000_0000 - ub)) % 64'h1_0000_0000);
            else r = 32'((ua + ub) % 64'h1_0000_0000);
          end
          3'd1: r = 32'((ua * p) % 64'h1_0000_0000);
          3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
          3'd3: r = (ua < ub) ? 32'd1 : 32'd0;
          3'd4: r = vrs1 ^ b;
          3'd5: begin
            if (vimm[10]) begin
              q = sa / longint'(p);
              if (sa < 0 && q * longint'(p) != sa) q = q - 64'sd1;
              r = 32'(q);
            end else begin
              r = 32'(ua / p);
            end
          end
          3'd6: r = vrs1 | b;
          default: r = vrs1 & b;
        endcase
        if (op == 3'd5 && f3 == 3'd1 && vimm[11:5] != 7'h00) flt = 1'b1;
        if (op == 3'd5 && f3 == 3'd5 && !(vimm[11:5] == 7'h00 || vimm[11:5] == 7'h20)) flt = 1'b1;
        if (op == 3'd6 && vimm[10] && !(f3 == 3'd0 || f3 == 3'd5)) flt = 1'b1;
      end
      default: begin
        r = 32'd0;
        flt = 1'b1;
      end
    endcase
    return {flt, r};
  endfunction

  function automatic logic [31:0] ref_addr(input logic [1:0] aop, input logic [31:0] vpc,
                                           input logic [31:0] vrs1, input logic [31:0] vimm);
    longint unsigned s;
    case (aop)
      2'd0: s = {32'd0, vpc};
      2'd1: s = {32'd0, vpc} + {32'd0, vimm};
      2'd2: s = {32'd0, vrs1} + {32'd0, vimm};
      default: s = {32'd0, vpc} + 64'd2;
    endcase
    return 32'(s % 64'h1_0000_0000);
  endfunction

  initial begin
    logic        exp_sticky;
    logic [32:0] r;
    logic [31:0] ri;

    rst_n = 1'b0;
    drive(3'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    #2;
    check("reset_sticky", {31'd0, fault_sticky}, 32'd0);

    // Reset must win over a fault present across a clock edge.
    alu_op = 3'd7;
    @(posedge clk); #1;
    check("reset_priority_sticky", {31'd0, fault_sticky}, 32'd0);
    alu_op = 3'd0;
    #1 rst_n = 1'b1;

    //       op    aop   f3    pc            rs1           rs2           imm           exp_out       exp_addr  flt
    add_vec(3'd0, 2'd0, 3'd0, 32'h0,        32'h0,        32'h0,        32'hFF,       32'hFF,       32'h0,    1'b0);
    add_vec(3'd1, 2'd0, 3'd0, 32'h4,        32'h0,        32'h0,        32'h0,        32'h8,        32'h4,    1'b0);
    add_vec(3'd4, 2'd0, 3'd0, 32'h0,        32'h0,        32'hBB,       32'h0,        32'hBB,       32'h0,    1'b0);
    add_vec(3'd2, 2'd0, 3'd0, 32'h100,      32'h0,        32'h0,        32'hFFFFFFF0, 32'hF0,       32'h100,  1'b0);
    add_vec(3'd5, 2'd0, 3'd0, 32'h0,        32'd10,       32'h0,        32'd22,       32'd32,       32'h0,    1'b0);
    add_vec(3'd5, 2'd0, 3'd2, 32'h0,        32'd1,        32'h0,        32'hFFFFFFFF, 32'd0,        32'h0,    1'b0);
    add_vec(3'd5, 2'd0, 3'd3, 32'h0,        32'd1,        32'h0,        32'hFFFFFFFF, 32'd1,        32'h0,    1'b0);
    add_vec(3'd5, 2'd0, 3'd4, 32'h0,        32'd2,        32'h0,        32'd3,        32'd1,        32'h0,    1'b0);
    add_vec(3'd5, 2'd0, 3'd6, 32'h0,        32'd2,        32'h0,        32'd3,        32'd3,        32'h0,    1'b0);
    add_vec(3'd5, 2'd0, 3'd7, 32'h0,        32'd2,        32'h0,        32'd3,        32'd2,        32'h0,    1'b0);
    add_vec(3'd5, 2'd0, 3'd1, 32'h0,        32'd1,        32'h0,        32'd2,        32'd4,        32'h0,    1'b0);
    add_vec(3'd5, 2'd0, 3'd5, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h010,      32'h0000FFFF, 32'h0,    1'b0);
    add_vec(3'd5, 2'd0, 3'd5, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h410,      32'hFFFFFFFF, 32'h0,    1'b0);
    add_vec(3'd6, 2'd0, 3'd0, 32'h0,        32'd1,        32'hFFFFFFFE, 32'h0,        32'hFFFFFFFF, 32'h0,    1'b0);
    add_vec(3'd6, 2'd0, 3'd0, 32'h0,        32'd1,        32'hFFFFFFFE, 32'h400,      32'd3,        32'h0,    1'b0);
    add_vec(3'd6, 2'd0, 3'd1, 32'h0,        32'd1,        32'd4,        32'h0,        32'h10,       32'h0,    1'b0);
    add_vec(3'd6, 2'd0, 3'd2, 32'h0,        32'd1,        32'hFFFFFFFF, 32'h0,        32'd0,        32'h0,    1'b0);
    add_vec(3'd6, 2'd0, 3'd3, 32'h0,        32'd1,        32'hFFFFFFFF, 32'h0,        32'd1,        32'h0,    1'b0);
    add_vec(3'd6, 2'd0, 3'd4, 32'h0,        32'hF0,       32'h0F,       32'h0,        32'hFF,       32'h0,    1'b0);
    add_vec(3'd6, 2'd0, 3'd5, 32'h0,        32'hFFFF0000, 32'hF0000010, 32'h0,        32'h0000FFFF, 32'h0,    1'b0);
    add_vec(3'd6, 2'd0, 3'd5, 32'h0,        32'hFFFF0000, 32'hF0000010, 32'h400,      32'hFFFFFFFF, 32'h0,    1'b0);
    add_vec(3'd6, 2'd0, 3'd6, 32'h0,        32'hFFFF0000, 32'hF0000010, 32'h0,        32'hFFFF0010, 32'h0,    1'b0);
    add_vec(3'd6, 2'd0, 3'd7, 32'h0,        32'hFFFF0000, 32'hF0000010, 32'h0,        32'hF0000000, 32'h0,    1'b0);
    add_vec(3'd0, 2'd0, 3'd0, 32'hF0,       32'd2,        32'h0,        32'd3,        32'd3,        32'hF0,   1'b0);
    add_vec(3'd0, 2'd1, 3'd0, 32'hF0,       32'd2,        32'h0,        32'd3,        32'd3,        32'hF3,   1'b0);
    add_vec(3'd0, 2'd2, 3'd0, 32'hF0,       32'd2,        32'h0,        32'd3,        32'd3,        32'd5,    1'b0);
    add_vec(3'd0, 2'd3, 3'd0, 32'hF0,       32'd2,        32'h0,        32'd3,        32'd3,        32'hF2,   1'b0);
    add_vec(3'd3, 2'd0, 3'd0, 32'h0,        32'd5,        32'd5,        32'd5,        32'd0,        32'h0,    1'b1);
    add_vec(3'd5, 2'd0, 3'd1, 32'h0,        32'd1,        32'h0,        32'h022,      32'd4,        32'h0,    1'b1);
    add_vec(3'd5, 2'd0, 3'd5, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h610,      32'hFFFFFFFF, 32'h0,    1'b1);
    add_vec(3'd6, 2'd0, 3'd4, 32'h0,        32'hF0,       32'h0F,       32'h400,      32'hFF,       32'h0,    1'b1);
    add_vec(3'd6, 2'd0, 3'd1, 32'h0,        32'd1,        32'd4,        32'h400,      32'h10,       32'h0,    1'b1);

    for (int i = 0; i < vec_q.size(); i++) begin
      drive(vec_q[i].op, vec_q[i].aop, vec_q[i].f3, vec_q[i].pc, vec_q[i].rs1, vec_q[i].rs2, vec_q[i].imm);
      #1;
      check($sformatf("vec%0d_alu_out", i), alu_out, vec_q[i].exp_out);
      check($sformatf("vec%0d_addr", i), addr_alu_out, vec_q[i].exp_addr);
      check($sformatf("vec%0d_fault", i), {31'd0, fault}, {31'd0, vec_q[i].exp_fault});
    end

    // Fault sequence: set, hold, then asynchronous clear without a clock edge.
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    drive(3'd7, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    check("rsv7_fault", {31'd0, fault}, 32'd1);
    check("rsv7_alu_out", alu_out, 32'd0);
    check("sticky_before_edge", {31'd0, fault_sticky}, 32'd0);
    @(posedge clk); #1;
    check("sticky_set", {31'd0, fault_sticky}, 32'd1);
    alu_op = 3'd0;
    #1;
    check("fault_cleared", {31'd0, fault}, 32'd0);
    @(posedge clk); #1;
    check("sticky_held", {31'd0, fault_sticky}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("sticky_async_clear", {31'd0, fault_sticky}, 32'd0);
    rst_n = 1'b1;

    // Random stimulus against the reference model, sticky tracked alongside.
    exp_sticky = 1'b0;
    for (int i = 0; i < 400; i++) begin
      ri = $urandom;
      if ($urandom_range(0, 1) == 1) ri[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      drive(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            $urandom, $urandom, $urandom, ri);
      #1;
      r = ref_alu(alu_op, funct3, pc, rs1, rs2, imm);
      check($sformatf("rnd%0d_alu_out op=%0d f3=%0d", i, alu_op, funct3), alu_out, r[31:0]);
      check($sformatf("rnd%0d_fault op=%0d f3=%0d", i, alu_op, funct3), {31'd0, fault}, {31'd0, r[32]});
      check($sformatf("rnd%0d_addr aop=%0d", i, addr_alu_op), addr_alu_out,
            ref_addr(addr_alu_op, pc, rs1, imm));
      exp_sticky = exp_sticky | r[32];
      @(posedge clk); #1;
      check($sformatf("rnd%0d_sticky", i), {31'd0, fault_sticky}, {31'd0, exp_sticky});
      if ((i % 100) == 99) begin
        rst_n = 1'b0;
        #1;
        exp_sticky = 1'b0;
        check($sformatf("rnd%0d_sticky_reset", i), {31'd0, fault_sticky}, 32'd0);
        rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
Execute-stage arithmetic block for an RV32I core. Produces the integer result (alu_out) from pc, rs1, rs2, imm and funct3 under control of alu_op. Produces an address result (addr_alu_out) for branch, jump and load/store targets under control of addr_alu_op. Both datapaths are purely combinational. The only clocked state is a sticky fault status register.

Parameters:
XLEN, 32, datapath width. Only 32 is supported.

Ports:
clk  input  1  clock; used only by fault_sticky
rst_n  input  1  asynchronous active-low reset
alu_op  input  3  integer-result select
addr_alu_op  input  2  address-result select
imm  input  32  sign-extended immediate; imm[10] carries instruction bit 30
rs1  input  32  source register 1 value
rs2  input  32  source register 2 value
pc  input  32  current instruction address
funct3  input  3  instruction funct3 field
alu_out  output  32  integer result (combinational)
addr_alu_out  output  32  address result (combinational)
fault  output  1  illegal operation encoding (combinational)
fault_sticky  output  1  registered OR of fault since reset

Behaviour:
- alu_out, addr_alu_out and fault are combinational. Zero latency; outputs are valid in the same delta as their inputs. They do not depend on clk or rst_n.
- Arithmetic is modulo 2^32. Overflow is ignored.
- alu_op encodings:
  - 0: imm (LUI)
  - 1: pc+4 (link address)
  - 2: pc+imm (AUIPC)
  - 3: reserved; alu_out=0, fault=1
  - 4: rs2 (store data pass-through)
  - 5: OP-IMM; operand B = imm; shift amount = imm[4:0]
  - 6: OP; operand B = rs2; shift amount = rs2[4:0]
  - 7: reserved; alu_out=0, fault=1
- funct3 decode for alu_op 5 and 6 (A = rs1):
  - 0: A+B. For op 6 only, imm[10]=1 selects A-B.
  - 1: A << shamt
  - 2: signed A<B, result 1 or 0
  - 3: unsigned A<B, result 1 or 0
  - 4: A^B
  - 5: imm[10]=0 gives logical right shift; imm[10]=1 gives arithmetic right shift. Applies to both op 5 and op 6.
  - 6: A|B
  - 7: A&B
- fault is also asserted, with alu_out still computed as decoded, when:
  - op 5, funct3=1, and imm[11:5] is not 0
  - op 5, funct3=5, and imm[11:5] is neither 0 nor 0x20
  - op 6, imm[10]=1, and funct3 is not 0 or 5
- addr_alu_op encodings:
  - 0: pc
  - 1: pc+imm (branch/JAL target)
  - 2: rs1+imm (load/store/JALR base)
  - 3: pc+2 (compressed-sequential address)
- fault_sticky:
  - Async clear to 0 when rst_n is low.
  - On each rising clk edge with rst_n high: fault_sticky <= fault_sticky | fault.
  - Reset has priority over a simultaneous fault.
  - Once set, it stays set until the next reset.
- Unknown or X inputs need not be handled.

Test Plan:
- alu_op=0, imm=0xFF -> alu_out=0xFF. alu_op=1, pc=4 -> 8. alu_op=4, rs2=0xBB -> 0xBB.
- alu_op=5, rs1=10, imm=22, funct3=0 -> 32.
  - rs1=1, imm=0xFFFFFFFF: funct3=2 -> 0; funct3=3 -> 1.
  - rs1=2, imm=3: funct3 4/6/7 -> 1/3/2.
  - rs1=1, imm=2, funct3=1 -> 4.
  - rs1=0xFFFFFFFF, funct3=5: imm=0x010 -> 0x0000FFFF; imm=0x410 -> 0xFFFFFFFF.
- alu_op=6, rs1=1, rs2=0xFFFFFFFE, funct3=0: imm=0 -> 0xFFFFFFFF; imm=0x400 -> 3.
  - imm=0: funct3=1 with rs2=4 -> 0x10.
  - rs1=1, rs2=0xFFFFFFFF: funct3 2/3 -> 0/1.
  - rs1=0xF0, rs2=0x0F, funct3=4 -> 0xFF.
- alu_op=6, rs1=0xFFFF0000, rs2=0xF0000010:
  - funct3=5 with imm 0/0x400 -> 0x0000FFFF/0xFFFFFFFF.
  - funct3=6 -> 0xFFFF0010; funct3=7 -> 0xF0000000.
  - fault=0 throughout.
- pc=0xF0, imm=3, rs1=2: addr_alu_op 0/1/2/3 -> 0xF0/0xF3/5/0xF2.
- Fault path:
  - alu_op=7 -> fault=1, alu_out=0. One clk edge later -> fault_sticky=1.
  - Return to alu_op=0 -> fault=0, fault_sticky stays 1.
  - Pulse rst_n low with no clock -> fault_sticky=0 immediately.
